// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared definitions for the async FIFO pointer blocks. Holds the
//            default address width and the Gray/binary conversion helpers.
// Contents : c_addr_size_default - default memory address width
//            bin2gray / gray2bin  - width-independent conversions
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_addr_size_default = 4;

    // Widest pointer the helpers accept.
    localparam int c_max_width = 32;

    // The helpers work on a zero-extended vector. Leading zeros do not change
    // either conversion, so one function serves every pointer width. Callers
    // size the result back down with a cast.
    function automatic logic [c_max_width-1:0] bin2gray(input logic [c_max_width-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [c_max_width-1:0] gray2bin(input logic [c_max_width-1:0] gray);
        logic [c_max_width-1:0] bin;
        bin[c_max_width-1] = gray[c_max_width-1];
        for (int i = c_max_width - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_2ff
// Purpose  : Two-flop synchronizer for a multi-bit Gray-coded bus. Only one
//            bit of the input changes at a time, so the output is always
//            either the old value or the new value.
// Ports    : clk   - destination clock
//            rst_n - asynchronous active-low reset, clears both stages
//            i_d   - bus from the foreign clock domain
//            o_q   - synchronized bus
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_ptr_full
// Purpose  : Write-domain pointer and flag generator for the async FIFO.
//            This block drives the memory write address and enable. It
//            publishes a Gray write pointer to the read domain. It also
//            derives full, almost-full and occupancy from the synchronized
//            read pointer.
// Ports    : clk            - write clock
//            rst_n          - asynchronous active-low reset
//            wr_inc         - producer write request
//            rd_ptr_gray    - read pointer (Gray), asynchronous to clk
//            wr_addr        - memory write address
//            en             - memory write enable (wr_inc && !wr_full)
//            wr_full        - registered full flag
//            wr_almost_full - registered, occupancy >= AFULL_THRESH
//            wr_count       - registered occupancy, 0..DEPTH
//            wr_ptr_gray    - registered Gray write pointer
//            wr_overflow    - sticky dropped-write flag (optional)
// Options  : WR_OVERFLOW_FLAG_EN - when defined, adds the wr_overflow output
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = c_addr_size_default,
    parameter int AFULL_THRESH = (1 << ADDR_SIZE) - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_inc,
    input  logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic                 en,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [ADDR_SIZE:0]   wr_count,
    output logic [ADDR_SIZE:0]   wr_ptr_gray
`ifdef WR_OVERFLOW_FLAG_EN
    ,
    output logic                 wr_overflow
`endif
);

    localparam int                c_ptr_w        = ADDR_SIZE + 1;
    localparam logic [c_ptr_w-1:0] c_afull_thresh = c_ptr_w'(AFULL_THRESH);

    logic [c_ptr_w-1:0] r_wbin;
    logic [c_ptr_w-1:0] r_wgray;
    logic               r_full;
    logic               r_afull;
    logic [c_ptr_w-1:0] r_count;

    logic [c_ptr_w-1:0] w_rq2;
    logic [c_ptr_w-1:0] w_rbin;
    logic               w_accept;
    logic [c_ptr_w-1:0] w_wbin_next;
    logic [c_ptr_w-1:0] w_wgray_next;
    logic [c_ptr_w-1:0] w_full_cmp;
    logic [c_ptr_w-1:0] w_count_next;

    // Read pointer into the write domain.
    fifo_sync_2ff #(
        .WIDTH (c_ptr_w)
    ) u_rd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rd_ptr_gray),
        .o_q   (w_rq2)
    );

    assign w_rbin       = c_ptr_w'(gray2bin(c_max_width'(w_rq2)));
    assign w_accept     = wr_inc & ~r_full;
    assign w_wbin_next  = r_wbin + c_ptr_w'(w_accept);
    assign w_wgray_next = c_ptr_w'(bin2gray(c_max_width'(w_wbin_next)));

    // The FIFO is full when the write pointer is exactly one lap ahead of
    // the read pointer. In Gray code this means the two MSBs are inverted
    // and the remaining bits are equal.
    generate
        if (ADDR_SIZE == 1) begin : g_full_cmp_narrow
            assign w_full_cmp = ~w_rq2;
        end else begin : g_full_cmp_wide
            assign w_full_cmp = {~w_rq2[ADDR_SIZE:ADDR_SIZE-1], w_rq2[ADDR_SIZE-2:0]};
        end
    endgenerate

    // Modular difference. The synchronized read pointer can only lag the
    // true read pointer, so this value never understates the occupancy.
    assign w_count_next = w_wbin_next - w_rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_count <= '0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= (w_wgray_next == w_full_cmp);
            r_afull <= (w_count_next >= c_afull_thresh);
            r_count <= w_count_next;
        end
    end

`ifdef WR_OVERFLOW_FLAG_EN
    logic r_overflow;

    // Sticky until reset so that a single dropped write is never missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_inc && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign wr_overflow = r_overflow;
`endif

    assign wr_addr        = r_wbin[ADDR_SIZE-1:0];
    assign en             = w_accept;
    assign wr_full        = r_full;
    assign wr_almost_full = r_afull;
    assign wr_count       = r_count;
    assign wr_ptr_gray    = r_wgray;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_ptr_full
// Purpose  : Self-checking bench for fifo_wr_ptr_full (ADDR_SIZE=4,
//            AFULL_THRESH=14). The reference model tracks absolute counts of
//            accepted writes and of read positions. It applies the two-edge
//            synchronizer delay to the read count and derives the expected
//            flags from the arithmetic difference.
// Options  : WR_OVERFLOW_FLAG_EN - also checks the wr_overflow output
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ptr_full;

    localparam int c_addr  = 4;
    localparam int c_depth = 1 << c_addr;
    localparam int c_afull = 14;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_inc = 1'b0;
    logic [c_addr:0]   rd_ptr_gray = '0;
    logic [c_addr-1:0] wr_addr;
    logic              en;
    logic              wr_full;
    logic              wr_almost_full;
    logic [c_addr:0]   wr_count;
    logic [c_addr:0]   wr_ptr_gray;
`ifdef WR_OVERFLOW_FLAG_EN
    logic              wr_overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_wabs  = 0;  // accepted writes since reset
    int rd_abs  = 0;  // read position driven on rd_ptr_gray
    int h1      = 0;  // read position sampled one edge ago
    int h2      = 0;  // read position sampled two edges ago
    int m_count = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_ovf   = 0;
    logic [c_addr:0] prev_gray = '0;

    fifo_wr_ptr_full #(
        .ADDR_SIZE    (c_addr),
        .AFULL_THRESH (c_afull)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_inc         (wr_inc),
        .rd_ptr_gray    (rd_ptr_gray),
        .wr_addr        (wr_addr),
        .en             (en),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_count       (wr_count),
        .wr_ptr_gray    (wr_ptr_gray)
`ifdef WR_OVERFLOW_FLAG_EN
        ,
        .wr_overflow    (wr_overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [c_addr:0] to_gray(input int b);
        logic [c_addr:0] x;
        x = b[c_addr:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. The bench drives wr_inc and moves the read position
    // toward rd_tgt, but never past the data actually written. It then
    // checks the DUT against the model.
    task automatic step(input logic inc, input int rd_tgt);
        int rs;
        int tgt;
        tgt = rd_tgt;
        if (tgt > m_wabs) tgt = m_wabs;
        if (tgt < rd_abs) tgt = rd_abs;
        rd_abs      = tgt;
        wr_inc      = inc;
        rd_ptr_gray = to_gray(rd_abs % (2 * c_depth));
        #1;
        chk("en", {31'd0, en}, {31'd0, inc && !m_full});
        @(posedge clk);
        rs = h2;
        h2 = h1;
        h1 = rd_abs;
        if (inc && m_full) m_ovf = 1;
        if (inc && !m_full) m_wabs++;
        m_count = m_wabs - rs;
        m_full  = (m_count == c_depth);
        m_afull = (m_count >= c_afull);
        #1;
        chk("wr_addr", 32'(wr_addr), 32'(m_wabs % c_depth));
        chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wabs % (2 * c_depth))));
        chk("wr_full", {31'd0, wr_full}, {31'd0, m_full});
        chk("wr_almost_full", {31'd0, wr_almost_full}, {31'd0, m_afull});
        chk("wr_count", 32'(wr_count), 32'(m_count));
        chk("gray_hamming", {31'd0, $countones(wr_ptr_gray ^ prev_gray) <= 1}, 32'd1);
        prev_gray = wr_ptr_gray;
`ifdef WR_OVERFLOW_FLAG_EN
        chk("wr_overflow", {31'd0, wr_overflow}, {31'd0, m_ovf});
`endif
    endtask

    // Asynchronous reset in the middle of a cycle. Outputs must clear at
    // once, and en follows wr_inc while reset is asserted.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_full", {31'd0, wr_full}, 32'd0);
        chk("rst_wr_almost_full", {31'd0, wr_almost_full}, 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 32'd0);
        chk("rst_en", {31'd0, en}, {31'd0, wr_inc});
`ifdef WR_OVERFLOW_FLAG_EN
        chk("rst_wr_overflow", {31'd0, wr_overflow}, 32'd0);
`endif
        wr_inc      = 1'b0;
        rd_ptr_gray = '0;
        m_wabs = 0; rd_abs = 0; h1 = 0; h2 = 0;
        m_count = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        prev_gray = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wr_count", 32'(wr_count), 32'd0);
    endtask

    initial begin
        #3;
        do_reset();

        // Fill from empty with the reader idle.
        for (int i = 0; i < c_depth; i++) step(1'b1, 0);
        chk("fill_full", {31'd0, wr_full}, 32'd1);
        chk("fill_count", 32'(wr_count), 32'(c_depth));
        chk("fill_afull", {31'd0, wr_almost_full}, 32'd1);

        // Write while full is dropped.
        step(1'b1, 0);
        chk("drop_wr_addr", 32'(wr_addr), 32'd0);
        chk("drop_gray", 32'(wr_ptr_gray), 32'(to_gray(c_depth)));

        // One read frees a slot after the synchronizer latency.
        for (int i = 0; i < 3; i++) step(1'b0, 1);
        chk("release_full", {31'd0, wr_full}, 32'd0);
        chk("release_count", 32'(wr_count), 32'(c_depth - 1));

        // Steady streaming across the pointer wrap.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, m_wabs - 4);
            chk("wrap_no_full", {31'd0, wr_full}, 32'd0);
        end

        // Random traffic: a slow reader first (pushes into full), then a fast one.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) step($urandom_range(0, 3) != 0, rd_abs + int'($urandom_range(0, 2) == 0));
            else         step($urandom_range(0, 1) != 0, rd_abs + int'($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 0);
        chk("burst_count", 32'(wr_count), 32'd9);
        wr_inc = 1'b1;
        do_reset();
        wr_inc = 1'b1;
        #1;
        chk("first_addr", 32'(wr_addr), 32'd0);
        step(1'b1, 0);
        chk("second_addr", 32'(wr_addr), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
